// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control FSM.
// State encoding, instruction field codes, ALU op codes, and datapath
// mux encodings used by mc_control and mc_alu_decode.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_WB_R    = 4'd4,
    S_EXEC_I  = 4'd5,
    S_WB_I    = 4'd6,
    S_ADDR    = 4'd7,
    S_MEM_RD  = 4'd8,
    S_WB_MEM  = 4'd9,
    S_MEM_WR  = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_MOVE = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOT  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SGT  = 6'h2B;

  // ALU operation codes, shared with the ALU
  localparam logic [4:0] ALU_MOVE = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_NOT  = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SGT  = 5'd9;

  // aluSrcB selections
  localparam logic [1:0] SRCB_REGB   = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // pcSource selections
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational R-type funct -> ALU op mapping.
// valid is low for any funct the ALU does not implement; alu_op is then 0.
module mc_alu_decode
  import mc_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 5
) (
  input  logic [OPW-1:0]    funct,
  output logic [ALUOPW-1:0] alu_op,
  output logic              valid
);

  // Map each supported funct onto its ALU encoding
  always_comb begin
    alu_op = ALU_MOVE;
    valid  = 1'b1;
    case (funct)
      FN_MOVE: alu_op = ALU_MOVE;
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_NOT:  alu_op = ALU_NOT;
      FN_XOR:  alu_op = ALU_XOR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_SGT:  alu_op = ALU_SGT;
      default: begin
        alu_op = ALU_MOVE;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM for a MIPS-style datapath.
// Sequences one instruction over 3-5 cycles; outputs are decoded from the
// state register plus opcode/funct/zero/memReady (no output registers).
// Optional build macro MC_ILLEGAL_TRAP_EN: when defined the ILLEGAL state
// raises illegal=1 and traps until reset; otherwise ILLEGAL is a one-cycle
// NOP that returns to FETCH and illegal stays 0.
module mc_control
  import mc_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [OPW-1:0]    opcode,
  input  logic [OPW-1:0]    funct,
  input  logic              zero,
  input  logic              memReady,
  output logic [ALUOPW-1:0] aluOp,
  output logic              aluSrcA,
  output logic [1:0]        aluSrcB,
  output logic              iord,
  output logic              memRead,
  output logic              memWrite,
  output logic              irWrite,
  output logic              pcWrite,
  output logic [1:0]        pcSource,
  output logic              regWrite,
  output logic              regDst,
  output logic              memToReg,
  output logic              illegal
);

  state_t              state_q;
  state_t              state_d;
  logic [ALUOPW-1:0]   fn_alu_op_s;
  logic                fn_valid_s;

  mc_alu_decode #(.OPW(OPW), .ALUOPW(ALUOPW)) u_alu_decode (
    .funct  (funct),
    .alu_op (fn_alu_op_s),
    .valid  (fn_valid_s)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore/instruction-decoded outputs
  always_comb begin
    state_d  = state_q;
    aluOp    = ALU_MOVE;
    aluSrcA  = 1'b0;
    aluSrcB  = SRCB_REGB;
    iord     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSource = PCSRC_ALU;
    regWrite = 1'b0;
    regDst   = 1'b0;
    memToReg = 1'b0;
    illegal  = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        aluOp   = ALU_ADD;
        // IR and PC+4 are committed only in the cycle memory completes
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        aluSrcB = SRCB_IMM_SH;
        aluOp   = ALU_ADD;
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_ILLEGAL;
        endcase
      end

      S_EXEC_R: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_REGB;
        aluOp   = fn_alu_op_s;
        if (fn_valid_s) begin
          state_d = S_WB_R;
        end else begin
          state_d = S_ILLEGAL;
        end
      end

      S_WB_R: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
        state_d  = S_FETCH;
      end

      S_EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALU_ADD;
        state_d = S_WB_I;
      end

      S_WB_I: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALU_ADD;
        if (opcode == OP_LW) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_MEM_WR;
        end
      end

      S_MEM_RD: begin
        memRead = 1'b1;
        iord    = 1'b1;
        if (memReady) begin
          state_d = S_WB_MEM;
        end else begin
          state_d = S_MEM_RD;
        end
      end

      S_WB_MEM: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_WR: begin
        // Strobe held for the whole stall so memory sees a stable request
        memWrite = 1'b1;
        iord     = 1'b1;
        if (memReady) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_WR;
        end
      end

      S_BRANCH: begin
        aluSrcA  = 1'b1;
        aluSrcB  = SRCB_REGB;
        aluOp    = ALU_SUB;
        pcSource = PCSRC_ALUOUT;
        // Only BEQ/BNE reach here; anything not BEQ is treated as BNE
        if (opcode == OP_BEQ) begin
          pcWrite = zero;
        end else begin
          pcWrite = ~zero;
        end
        state_d = S_FETCH;
      end

      S_JUMP: begin
        pcSource = PCSRC_JUMP;
        pcWrite  = 1'b1;
        state_d  = S_FETCH;
      end

      S_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
        illegal = 1'b1;
        state_d = S_ILLEGAL;
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the stimulus process drives one cycle of
// inputs and pushes the expected output vector; a negedge monitor pops and
// compares against the DUT outputs.
module tb_mc_control;

  typedef struct packed {
    logic [4:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       reg_wr;
    logic       reg_dst;
    logic       m2r;
    logic       ill;
  } ovec_t;

  typedef struct {
    ovec_t v;
    string nm;
  } sb_t;

  logic       clock;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       memReady;
  logic [4:0] aluOp;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic       iord;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       pcWrite;
  logic [1:0] pcSource;
  logic       regWrite;
  logic       regDst;
  logic       memToReg;
  logic       illegal;

  sb_t sbq[$];
  int  total = 0;
  int  bad   = 0;

  mc_control #(.OPW(6), .ALUOPW(5)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .memReady (memReady),
    .aluOp    (aluOp),
    .aluSrcA  (aluSrcA),
    .aluSrcB  (aluSrcB),
    .iord     (iord),
    .memRead  (memRead),
    .memWrite (memWrite),
    .irWrite  (irWrite),
    .pcWrite  (pcWrite),
    .pcSource (pcSource),
    .regWrite (regWrite),
    .regDst   (regDst),
    .memToReg (memToReg),
    .illegal  (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic ovec_t mk(input logic [4:0] a, input logic sa, input logic [1:0] sb,
                               input logic io, input logic mr, input logic mw, input logic irw,
                               input logic pcw, input logic [1:0] pcs, input logic rw,
                               input logic rd, input logic m2r, input logic il);
    ovec_t o;
    o = '{a, sa, sb, io, mr, mw, irw, pcw, pcs, rw, rd, m2r, il};
    return o;
  endfunction

  // Expected outputs per state, written from the control table
  function automatic ovec_t e_zero();
    return mk(5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_fetch(input logic mr);
    return mk(5'd1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, mr, mr, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_decode();
    return mk(5'd1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_exec_r(input logic [4:0] a);
    return mk(a, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_wb_r();
    return mk(5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_exec_i();
    return mk(5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_wb_i();
    return mk(5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_mem_rd();
    return mk(5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_wb_mem();
    return mk(5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic ovec_t e_mem_wr();
    return mk(5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_branch(input logic pcw);
    return mk(5'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, pcw, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_jump();
    return mk(5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic ovec_t e_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
    return mk(5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    return e_zero();
`endif
  endfunction

  // One clock of stimulus; optionally queue the expected outputs for it
  task automatic cyc(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic chk,
                     input ovec_t e, input string nm);
    sb_t s;
    @(posedge clock);
    #1;
    reset_n  = rn;
    opcode   = op;
    funct    = fn;
    zero     = z;
    memReady = mr;
    if (chk) begin
      s.v  = e;
      s.nm = nm;
      sbq.push_back(s);
    end
  endtask

  // Illegal-state handling differs by build; leaves the FSM ready to FETCH
  task automatic illegal_tail(input logic [5:0] op, input string nm);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) cyc(1'b1, op, 6'h00, 1'b0, 1'b1, 1'b1, e_illegal(), nm);
    cyc(1'b0, op, 6'h00, 1'b0, 1'b1, 1'b1, e_illegal(), {nm, "_at_reset"});
    cyc(1'b1, op, 6'h00, 1'b0, 1'b1, 1'b1, e_zero(), {nm, "_idle"});
`else
    cyc(1'b1, op, 6'h00, 1'b0, 1'b1, 1'b1, e_illegal(), nm);
`endif
  endtask

  // Monitor: every cycle with a queued expectation, compare all outputs
  always @(negedge clock) begin
    ovec_t obs;
    sb_t   s;
    if (sbq.size() != 0) begin
      s   = sbq.pop_front();
      obs = '{aluOp, aluSrcA, aluSrcB, iord, memRead, memWrite, irWrite, pcWrite,
              pcSource, regWrite, regDst, memToReg, illegal};
      total++;
      if (obs !== s.v) begin
        bad++;
        $display("FAIL %s: got=%05h want=%05h", s.nm, obs, s.v);
      end
    end
  end

  logic [5:0] fn_tab [9] = '{6'h21, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2A, 6'h2B};
  logic [4:0] op_tab [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};

  initial begin
    reset_n  = 1'b0;
    opcode   = 6'h00;
    funct    = 6'h00;
    zero     = 1'b0;
    memReady = 1'b0;

    // Reset held two cycles, then released: IDLE with all outputs 0, then FETCH
    cyc(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, e_zero(), "reset_idle0");
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, e_zero(), "reset_idle1");

    // FETCH stall two cycles, then R-type add
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, e_fetch(1'b0), "fetch_stall0");
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, e_fetch(1'b0), "fetch_stall1");
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "fetch_done");
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, e_decode(), "radd_decode");
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, e_exec_r(5'd1), "radd_exec");
    cyc(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, e_wb_r(), "radd_wb");

    // Every supported funct through EXEC_R
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 6'h00, fn_tab[i], 1'b0, 1'b1, 1'b1, e_fetch(1'b1), $sformatf("fn%02h_fetch", fn_tab[i]));
      cyc(1'b1, 6'h00, fn_tab[i], 1'b0, 1'b1, 1'b1, e_decode(), $sformatf("fn%02h_decode", fn_tab[i]));
      cyc(1'b1, 6'h00, fn_tab[i], 1'b0, 1'b1, 1'b1, e_exec_r(op_tab[i]), $sformatf("fn%02h_exec", fn_tab[i]));
      cyc(1'b1, 6'h00, fn_tab[i], 1'b0, 1'b1, 1'b1, e_wb_r(), $sformatf("fn%02h_wb", fn_tab[i]));
    end

    // ADDI
    cyc(1'b1, 6'h08, 6'h00, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "addi_fetch");
    cyc(1'b1, 6'h08, 6'h00, 1'b0, 1'b1, 1'b1, e_decode(), "addi_decode");
    cyc(1'b1, 6'h08, 6'h00, 1'b0, 1'b1, 1'b1, e_exec_i(), "addi_exec");
    cyc(1'b1, 6'h08, 6'h00, 1'b0, 1'b1, 1'b1, e_wb_i(), "addi_wb");

    // LW with three stall cycles in MEM_RD
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "lw_fetch");
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, e_decode(), "lw_decode");
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_exec_i(), "lw_addr");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b1, e_mem_rd(), $sformatf("lw_stall%0d", i));
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, e_mem_rd(), "lw_mem_done");
    cyc(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, e_wb_mem(), "lw_wb");

    // SW with one stall cycle
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "sw_fetch");
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, e_decode(), "sw_decode");
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, e_exec_i(), "sw_addr");
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, e_mem_wr(), "sw_stall");
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, e_mem_wr(), "sw_done");

    // Branches: BEQ/BNE with zero high and low
    cyc(1'b1, 6'h04, 6'h00, 1'b1, 1'b1, 1'b1, e_fetch(1'b1), "beq1_fetch");
    cyc(1'b1, 6'h04, 6'h00, 1'b1, 1'b1, 1'b1, e_decode(), "beq1_decode");
    cyc(1'b1, 6'h04, 6'h00, 1'b1, 1'b1, 1'b1, e_branch(1'b1), "beq_z1");
    cyc(1'b1, 6'h04, 6'h00, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "beq0_fetch");
    cyc(1'b1, 6'h04, 6'h00, 1'b0, 1'b1, 1'b1, e_decode(), "beq0_decode");
    cyc(1'b1, 6'h04, 6'h00, 1'b0, 1'b1, 1'b1, e_branch(1'b0), "beq_z0");
    cyc(1'b1, 6'h05, 6'h00, 1'b1, 1'b1, 1'b1, e_fetch(1'b1), "bne1_fetch");
    cyc(1'b1, 6'h05, 6'h00, 1'b1, 1'b1, 1'b1, e_decode(), "bne1_decode");
    cyc(1'b1, 6'h05, 6'h00, 1'b1, 1'b1, 1'b1, e_branch(1'b0), "bne_z1");
    cyc(1'b1, 6'h05, 6'h00, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "bne0_fetch");
    cyc(1'b1, 6'h05, 6'h00, 1'b0, 1'b1, 1'b1, e_decode(), "bne0_decode");
    cyc(1'b1, 6'h05, 6'h00, 1'b0, 1'b1, 1'b1, e_branch(1'b1), "bne_z0");

    // Jump
    cyc(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "j_fetch");
    cyc(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 1'b1, e_decode(), "j_decode");
    cyc(1'b1, 6'h02, 6'h00, 1'b0, 1'b1, 1'b1, e_jump(), "j_jump");

    // Illegal opcode 0x3F
    cyc(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "ilop_fetch");
    cyc(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, e_decode(), "ilop_decode");
    illegal_tail(6'h3F, "ilop_state");

    // Unsupported R-type funct
    cyc(1'b1, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "ilfn_fetch");
    cyc(1'b1, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b1, e_decode(), "ilfn_decode");
    cyc(1'b1, 6'h00, 6'h3F, 1'b0, 1'b1, 1'b1, e_exec_r(5'd0), "ilfn_exec");
    illegal_tail(6'h00, "ilfn_state");

    // Reset asserted during a MEM_WR stall
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, e_fetch(1'b1), "swr_fetch");
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, e_decode(), "swr_decode");
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, e_exec_i(), "swr_addr");
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, e_mem_wr(), "swr_stall");
    cyc(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, e_mem_wr(), "swr_rst_cycle");
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, e_zero(), "swr_idle");
    cyc(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, e_fetch(1'b0), "swr_refetch");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clock);
    #1;
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d pending want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
